// File: rtl/spi_master_gen.sv
`timescale 1ns / 1ps
// spi_master_gen - parametrised SPI master, all four modes per transaction.
//
// Parameters
//   DATA_W  : bits per word, shifted MSB first (>= 1)
//   CLK_DIV : SCLK half-period in clk cycles (>= 2)
//   NUM_CS  : number of active-low chip selects (>= 1)
//   CS_W    : width of cs_sel
//
// Ports
//   clk, rst          : system clock, synchronous active-high reset
//   start             : transaction request, taken only while busy = 0
//   cpol, cpha        : SPI mode, latched at accept
//   keep_cs           : leave the chip select asserted after this word
//   cs_sel            : target slave, ignored while a select is being held
//   data_in           : word to transmit, latched at accept
//   miso              : serial data from the slave
//   busy, done        : transfer in progress / one-cycle completion pulse
//   data_out          : received word, updated in the done cycle
//   sclk, mosi, cs_n  : SPI pins
module spi_master_gen #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4,
  parameter int NUM_CS  = 1,
  parameter int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              keep_cs,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [DATA_W-1:0] data_in,
  input  logic              miso,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data_out,
  output logic              sclk,
  output logic              mosi,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int EDGES  = 2 * DATA_W;
  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int ECNT_W = $clog2(EDGES + 1);

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL, S_GAP} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div;
  logic [ECNT_W-1:0] ecnt;
  logic              cpha_q;
  logic              keep_q;
  logic              cs_hold;
  logic [CS_W-1:0]   held_sel;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;

  logic              div_last;
  logic              edge_tick;
  logic [ECNT_W-1:0] edge_nxt;
  logic              last_edge;
  logic              sample_edge;
  logic              shift_edge;
  logic [CS_W-1:0]   acc_sel;

  assign div_last  = (div == DIV_W'(CLK_DIV - 1));
  assign edge_tick = div_last && ((state == S_LEAD) || (state == S_XFER));
  // edge_nxt is the 1-based number of the sclk edge produced on this tick
  assign edge_nxt  = ecnt + ECNT_W'(1);
  assign last_edge = (edge_nxt == ECNT_W'(EDGES));
  // odd edges lead, even edges trail; cpha swaps which one samples
  assign sample_edge = cpha_q ? ~edge_nxt[0] : edge_nxt[0];
  // with cpha=0 the MSB is already on mosi, so the final trailing edge has nothing left to shift
  assign shift_edge  = cpha_q ? edge_nxt[0] : (~edge_nxt[0] & ~last_edge);
  // a held select survives the IDLE state and overrides cs_sel on the next accept
  assign acc_sel = cs_hold ? held_sel : cs_sel;

  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (rst) begin
      state    <= S_IDLE;
      div      <= '0;
      ecnt     <= '0;
      busy     <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= '1;
      data_out <= '0;
      cs_hold  <= 1'b0;
    end else begin
      if (edge_tick) begin
        sclk <= ~sclk;
        ecnt <= edge_nxt;
        if (sample_edge) rx_sr <= (rx_sr << 1) | DATA_W'(miso);
        if (shift_edge) begin
          mosi  <= tx_sr[DATA_W-1];
          tx_sr <= tx_sr << 1;
        end
      end

      case (state)
        S_IDLE: begin
          div <= '0;
          if (start) begin
            state    <= S_LEAD;
            busy     <= 1'b1;
            ecnt     <= '0;
            cpha_q   <= cpha;
            keep_q   <= keep_cs;
            held_sel <= acc_sel;
            cs_n     <= ~(NUM_CS'(1) << acc_sel);
            sclk     <= cpol;
            if (!cpha) begin
              mosi  <= data_in[DATA_W-1];
              tx_sr <= data_in << 1;
            end else begin
              tx_sr <= data_in;
            end
          end
        end

        S_LEAD: begin
          if (div_last) begin
            div   <= '0;
            state <= S_XFER;
          end else begin
            div <= div + DIV_W'(1);
          end
        end

        S_XFER: begin
          if (div_last) begin
            div <= '0;
            if (last_edge) state <= S_TRAIL;
          end else begin
            div <= div + DIV_W'(1);
          end
        end

        S_TRAIL: begin
          if (div_last) begin
            div <= '0;
            if (keep_q) begin
              state    <= S_IDLE;
              busy     <= 1'b0;
              done     <= 1'b1;
              data_out <= rx_sr;
              cs_hold  <= 1'b1;
            end else begin
              state   <= S_GAP;
              cs_n    <= '1;
              cs_hold <= 1'b0;
            end
          end else begin
            div <= div + DIV_W'(1);
          end
        end

        S_GAP: begin
          if (div_last) begin
            div      <= '0;
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            data_out <= rx_sr;
          end else begin
            div <= div + DIV_W'(1);
          end
        end

        default: begin
          state <= S_IDLE;
          div   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_gen.sv
`timescale 1ns / 1ps
module tb_spi_master_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cpol, cpha, keep_cs;
  logic        start8, start16;
  logic [1:0]  cs_sel;
  logic [0:0]  cs_sel16;
  logic [15:0] data_in;
  logic        miso_drv, loop_en, which;

  logic        busy8, done8, sclk8, mosi8, miso8;
  logic [7:0]  dout8;
  logic [3:0]  csn8;
  logic        busy16, done16, sclk16, mosi16, miso16;
  logic [15:0] dout16;
  logic [0:0]  csn16;

  assign miso8  = loop_en ? mosi8  : miso_drv;
  assign miso16 = loop_en ? mosi16 : miso_drv;

  spi_master_gen #(.DATA_W(8), .CLK_DIV(4), .NUM_CS(4)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .cpol(cpol), .cpha(cpha),
    .keep_cs(keep_cs), .cs_sel(cs_sel), .data_in(data_in[7:0]), .miso(miso8),
    .busy(busy8), .done(done8), .data_out(dout8), .sclk(sclk8), .mosi(mosi8),
    .cs_n(csn8)
  );

  spi_master_gen #(.DATA_W(16), .CLK_DIV(2)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .cpol(cpol), .cpha(cpha),
    .keep_cs(keep_cs), .cs_sel(cs_sel16), .data_in(data_in), .miso(miso16),
    .busy(busy16), .done(done16), .data_out(dout16), .sclk(sclk16), .mosi(mosi16),
    .cs_n(csn16)
  );

  // observation mux: whichever instance is under test
  logic        o_busy, o_done, o_sclk, o_mosi;
  logic [15:0] o_dout;
  logic [3:0]  o_cs;
  assign o_busy = which ? busy16 : busy8;
  assign o_done = which ? done16 : done8;
  assign o_sclk = which ? sclk16 : sclk8;
  assign o_mosi = which ? mosi16 : mosi8;
  assign o_dout = which ? dout16 : {8'h00, dout8};
  assign o_cs   = which ? {3'b111, csn16} : csn8;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] exp_dout [2];
  bit          held     = 1'b0;
  int          held_idx = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction, started from the current negedge (cycle 0). Expected pin
  // activity is derived from the cycle number alone: edge k lands at 1+k*H.
  task automatic xfer(input bit w16, input bit pol, input bit pha, input bit keep,
                      input logic [1:0] sel, input logic [15:0] din, input logic [15:0] slv,
                      input bit loop, input int ign1, input int ign2,
                      input int hold_tail, input int rst_at);
    int W, H, D, n, j, bitidx, idx, ec;
    logic [15:0] word_rx;
    logic [3:0]  cs_exp;
    W  = w16 ? 16 : 8;
    H  = w16 ? 2 : 4;
    ec = 2 * W;
    D  = keep ? 1 + (ec + 1) * H : 1 + (ec + 2) * H;
    idx = w16 ? 0 : (held ? held_idx : int'(sel));
    word_rx = loop ? din : slv;
    if (!w16) word_rx = word_rx & 16'h00FF;
    which = w16; cpol = pol; cpha = pha; keep_cs = keep; cs_sel = sel;
    data_in = din; loop_en = loop;
    miso_drv = word_rx[W-1];
    if (w16) start16 = 1'b1; else start8 = 1'b1;
    for (int t = 1; t <= D; t++) begin
      @(negedge clk);
      start8 = 1'b0; start16 = 1'b0;
      if (t == ign1 || t == ign2 || (hold_tail > 0 && t >= D - hold_tail)) begin
        if (w16) start16 = 1'b1; else start8 = 1'b1;
      end
      if (rst_at > 0 && t == rst_at + 1) begin
        rst = 1'b0;
        held = 1'b0;
        exp_dout[0] = '0; exp_dout[1] = '0;
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done", o_done, 1'b0);
        chk("rst_sclk", o_sclk, 1'b0);
        chk("rst_mosi", o_mosi, 1'b0);
        chk("rst_cs_n", o_cs, 4'hF);
        chk("rst_dout", o_dout, 16'h0000);
        return;
      end
      n = (t - 1) / H;
      if (n > ec) n = ec;
      chk("sclk", o_sclk, pol ^ n[0]);
      cs_exp = (keep || t < 1 + (ec + 1) * H) ? ~(4'b0001 << idx) : 4'hF;
      if (w16) cs_exp = cs_exp | 4'hE;
      chk("cs_n", o_cs, cs_exp);
      chk("busy", o_busy, (t < D));
      chk("done", o_done, (t == D));
      if (!pha) bitidx = W - 1 - (((n > ec - 1) ? ec - 1 : n) / 2);
      else      bitidx = (n == 0) ? -1 : W - 1 - ((n - 1) / 2);
      if (bitidx >= 0) chk("mosi", o_mosi, din[bitidx]);
      if (t == D) exp_dout[w16] = word_rx;
      chk("data_out", o_dout, exp_dout[w16]);
      j = pha ? n / 2 : (n + 1) / 2;
      miso_drv = (j < W) ? word_rx[W-1-j] : 1'b0;
      if (rst_at > 0 && t == rst_at) rst = 1'b1;
    end
    if (!w16) begin
      held     = keep;
      held_idx = idx;
    end
  endtask

  task automatic idle_chk(input int cyc, input bit pol);
    logic [3:0] cs_exp;
    cs_exp = (held && !which) ? ~(4'b0001 << held_idx) : 4'hF;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      chk("idle_busy", o_busy, 1'b0);
      chk("idle_done", o_done, 1'b0);
      chk("idle_sclk", o_sclk, pol);
      chk("idle_cs_n", o_cs, cs_exp);
    end
  endtask

  bit          r_pol, r_pha, r_keep;
  logic [1:0]  r_sel;
  logic [15:0] r_din, r_slv;

  initial begin
    rst = 1'b1; cpol = 1'b0; cpha = 1'b0; keep_cs = 1'b0; start8 = 1'b0; start16 = 1'b0;
    cs_sel = 2'd0; cs_sel16 = 1'b0; data_in = '0; miso_drv = 1'b0; loop_en = 1'b0; which = 1'b0;
    exp_dout[0] = '0; exp_dout[1] = '0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset_busy", o_busy, 1'b0);
    chk("reset_done", o_done, 1'b0);
    chk("reset_sclk", o_sclk, 1'b0);
    chk("reset_mosi", o_mosi, 1'b0);
    chk("reset_cs_n", o_cs, 4'hF);
    chk("reset_dout", o_dout, 16'h0000);
    rst = 1'b0;

    // mode 0, looped back
    xfer(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h00A5, 16'h0000, 1'b1, 0, 0, 0, 0);
    idle_chk(3, 1'b0);

    // modes 1..3 against a slave answering 0xC3
    xfer(1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 16'h003C, 16'h00C3, 1'b0, 0, 0, 0, 0);
    idle_chk(3, 1'b0);
    xfer(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 16'h003C, 16'h00C3, 1'b0, 0, 0, 0, 0);
    idle_chk(3, 1'b1);
    xfer(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 16'h003C, 16'h00C3, 1'b0, 0, 0, 0, 0);
    idle_chk(3, 1'b1);

    // held chip select burst on slave 2; cs_sel change on word 2 must be ignored
    xfer(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 16'h000B, 16'h0096, 1'b0, 0, 0, 0, 0);
    idle_chk(3, 1'b0);
    xfer(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 16'h0000, 16'h005A, 1'b0, 0, 0, 0, 0);
    xfer(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 16'h0000, 16'h00E1, 1'b0, 0, 0, 0, 0);
    idle_chk(3, 1'b0);

    // start pulses while busy are dropped; start held into done is taken there
    xfer(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0071, 16'h0018, 1'b0, 10, 40, 3, 0);
    xfer(1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 16'h00E7, 16'h0042, 1'b0, 0, 0, 0, 0);
    idle_chk(2, 1'b0);

    // reset in the middle of a transfer, then a normal transfer
    xfer(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 16'h00FF, 16'h00AA, 1'b0, 0, 0, 0, 30);
    idle_chk(2, 1'b0);
    xfer(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 16'h0055, 16'h0033, 1'b0, 0, 0, 0, 0);
    idle_chk(2, 1'b0);

    // randomised words, modes, selects and holds
    for (int r = 0; r < 8; r++) begin
      r_pol  = 1'($urandom_range(0, 1));
      r_pha  = 1'($urandom_range(0, 1));
      r_keep = (r == 7) ? 1'b0 : 1'($urandom_range(0, 1));
      r_sel  = 2'($urandom_range(0, 3));
      r_din  = 16'($urandom_range(0, 255));
      r_slv  = 16'($urandom_range(0, 255));
      xfer(1'b0, r_pol, r_pha, r_keep, r_sel, r_din, r_slv, 1'b0, 0, 0, 0, 0);
      idle_chk(2, r_pol);
    end

    // 16-bit word at the minimum divider
    xfer(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h8001, 16'h4D2B, 1'b0, 0, 0, 0, 0);
    idle_chk(2, 1'b0);
    for (int r = 0; r < 3; r++) begin
      r_pol = 1'($urandom_range(0, 1));
      r_pha = 1'($urandom_range(0, 1));
      r_din = 16'($urandom_range(0, 65535));
      r_slv = 16'($urandom_range(0, 65535));
      xfer(1'b1, r_pol, r_pha, 1'b0, 2'd0, r_din, r_slv, 1'b0, 0, 0, 0, 0);
      idle_chk(2, r_pol);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
